// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master round-robin arbiter for the native memory bus
// Holds the grant for a whole transfer; a watchdog force-completes a stalled slave.
module mem_arbiter #(
   parameter int unsigned TIMEOUT      = 255,
   parameter logic [31:0] TIMEOUT_DATA = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_valid,
   output logic        m0_ready,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   output logic [31:0] m0_rdata,
   input  logic        m1_valid,
   output logic        m1_ready,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic [31:0] m1_rdata,
   output logic        s_valid,
   input  logic        s_ready,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_wstrb,
   input  logic [31:0] s_rdata,
   output logic [1:0]  grant,
   output logic        timeout
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state, state_nxt;
   logic [1:0]    grant_r, grant_nxt;
   logic          last, last_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          busy, sel1, mg_valid, fire;

   // Outputs are masked during reset so a dropped transfer never sees a ready pulse.
   assign busy     = (state == BUSY) && !rst;
   assign sel1     = grant_r[1];
   assign mg_valid = sel1 ? m1_valid : m0_valid;
   assign fire     = (TIMEOUT != 0) && busy && mg_valid && !s_ready && (cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         grant_r <= 2'b00;
         last    <= 1'b1;
         cnt     <= '0;
      end else begin
         state   <= state_nxt;
         grant_r <= grant_nxt;
         last    <= last_nxt;
         cnt     <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      grant_nxt = grant_r;
      last_nxt  = last;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (m0_valid || m1_valid) begin
               state_nxt = BUSY;
               cnt_nxt   = '0;
               // On a tie the master not served last wins.
               grant_nxt = (m1_valid && (!m0_valid || !last)) ? 2'b10 : 2'b01;
            end
         end
         BUSY: begin
            if (s_ready || fire) begin
               state_nxt = IDLE;
               grant_nxt = 2'b00;
               last_nxt  = sel1;
            end else if (!mg_valid) begin
               state_nxt = IDLE;
               grant_nxt = 2'b00;
            end else if (TIMEOUT != 0) begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      s_addr   = sel1 ? m1_addr : m0_addr;
      s_wdata  = sel1 ? m1_wdata : m0_wdata;
      s_valid  = busy && mg_valid && !fire;
      s_wstrb  = s_valid ? (sel1 ? m1_wstrb : m0_wstrb) : 4'h0;
      m0_ready = 1'b0;
      m1_ready = 1'b0;
      m0_rdata = 32'h0;
      m1_rdata = 32'h0;
      if (busy && grant_r[0]) begin
         m0_ready = s_ready || fire;
         m0_rdata = fire ? TIMEOUT_DATA : s_rdata;
      end
      if (busy && grant_r[1]) begin
         m1_ready = s_ready || fire;
         m1_rdata = fire ? TIMEOUT_DATA : s_rdata;
      end
      timeout = fire;
      grant   = grant_r;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_valid, m0_ready, m1_valid, m1_ready;
   logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
   logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
   logic        s_valid, s_ready;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic [1:0]  grant;
   logic        timeout;

   always #5 clk = ~clk;

   mem_arbiter #(.TIMEOUT(TO), .TIMEOUT_DATA(32'hFFFF_FFFF)) dut (
      .clk(clk), .rst(rst),
      .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
      .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
      .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_wstrb(s_wstrb), .s_rdata(s_rdata),
      .grant(grant), .timeout(timeout)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          m;
      logic [31:0] d;
      bit          chk;
   } exp_t;
   exp_t sb[$];

   // Slave model: 0 zero-wait, 1 registered, 2 stalled, 3 bench-forced ready
   int          mode = 0;
   logic        reg_rdy;
   logic        force_ready = 1'b0;
   logic        rd_ovr_en = 1'b0;
   logic [31:0] rd_ovr = 32'h0;

   always_ff @(posedge clk) reg_rdy <= (mode == 1) && s_valid && !reg_rdy;

   always_comb begin
      case (mode)
         0:       s_ready = |grant;
         1:       s_ready = reg_rdy;
         3:       s_ready = force_ready;
         default: s_ready = 1'b0;
      endcase
   end

   assign s_rdata = rd_ovr_en ? rd_ovr : (s_addr ^ 32'hC0DE_0000);

   function automatic logic [31:0] model_rd(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic idle_masters();
      m0_valid = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_wstrb = 4'h0;
      m1_valid = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_wstrb = 4'h0;
   endtask

   task automatic do_reset();
      idle_masters();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got=%b exp=00", grant); end
      checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_svalid got=%b exp=0", s_valid); end
      checks++; if (s_wstrb !== 4'h0) begin errors++; $display("FAIL reset_swstrb got=%h exp=0", s_wstrb); end
      checks++; if (m0_ready !== 1'b0 || m1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b%b exp=00", m0_ready, m1_ready); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
   endtask

   task automatic test_single();
      exp_t e;
      mode = 0; rd_ovr_en = 1'b1; rd_ovr = 32'h1234_5678;
      @(posedge clk); #1;
      m0_valid = 1'b1; m0_addr = 32'h1000; m0_wstrb = 4'h0;
      sb.push_back('{0, 32'h1234_5678, 1'b1});
      @(negedge clk);
      checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL single_idle_svalid got=%b exp=0", s_valid); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL single_svalid got=%b exp=1", s_valid); end
      checks++; if (grant !== 2'b01) begin errors++; $display("FAIL single_grant got=%b exp=01", grant); end
      checks++; if (s_addr !== 32'h1000) begin errors++; $display("FAIL single_saddr got=%h exp=1000", s_addr); end
      checks++; if (m0_ready !== 1'b1) begin errors++; $display("FAIL single_ready got=%b exp=1", m0_ready); end
      if (m0_ready === 1'b1 && sb.size() > 0) begin
         e = sb.pop_front();
         checks++; if (e.m != 0 || m0_rdata !== e.d) begin errors++; $display("FAIL single_rdata got=%h exp=%h", m0_rdata, e.d); end
      end
      @(posedge clk); #1;
      m0_valid = 1'b0; rd_ovr_en = 1'b0;
      @(negedge clk);
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL single_grant_after got=%b exp=00", grant); end
      checks++; if (m0_ready !== 1'b0) begin errors++; $display("FAIL single_ready_after got=%b exp=0", m0_ready); end
   endtask

   task automatic test_simultaneous();
      exp_t e;
      do_reset();
      mode = 1;
      sb.push_back('{0, 32'h0, 1'b0});
      sb.push_back('{1, model_rd(32'h1004), 1'b1});
      @(posedge clk); #1;
      m0_valid = 1'b1; m0_addr = 32'h2000; m0_wdata = 32'hDEAD_BEEF; m0_wstrb = 4'hF;
      m1_valid = 1'b1; m1_addr = 32'h1004; m1_wstrb = 4'h0;
      for (int i = 1; i <= 6; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (i <= 2) begin
            checks++; if (m1_ready !== 1'b0 || m1_rdata !== 32'h0) begin errors++; $display("FAIL sim_m1_blocked c%0d got=%b/%h exp=0/0", i, m1_ready, m1_rdata); end
         end
         if (i == 1) begin
            checks++; if (grant !== 2'b01) begin errors++; $display("FAIL sim_grant_m0 got=%b exp=01", grant); end
            checks++; if (s_wstrb !== 4'hF || s_addr !== 32'h2000 || s_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sim_write got=%h/%h/%h exp=F/2000/deadbeef", s_wstrb, s_addr, s_wdata); end
            checks++; if (m0_ready !== 1'b0) begin errors++; $display("FAIL sim_reg_latency got=%b exp=0", m0_ready); end
         end
         if (i == 3) begin
            checks++; if (grant !== 2'b00) begin errors++; $display("FAIL sim_idle_gap got=%b exp=00", grant); end
         end
         if (i == 4) begin
            checks++; if (grant !== 2'b10 || s_addr !== 32'h1004 || s_wstrb !== 4'h0) begin errors++; $display("FAIL sim_grant_m1 got=%b/%h/%h exp=10/1004/0", grant, s_addr, s_wstrb); end
         end
         if (m0_ready === 1'b1 || m1_ready === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin errors++; $display("FAIL sim_unexpected_ready cycle=%0d", i); end
            else begin
               e = sb.pop_front();
               if ((e.m == 0 && (i != 2 || m0_ready !== 1'b1)) || (e.m == 1 && (i != 5 || m1_ready !== 1'b1 || m1_rdata !== e.d)))
                  begin errors++; $display("FAIL sim_order cycle=%0d got=%b%b/%h exp=m%0d/%h", i, m1_ready, m0_ready, m1_rdata, e.m, e.d); end
            end
            if (m0_ready === 1'b1) m0_valid = 1'b0;
            if (m1_ready === 1'b1) m1_valid = 1'b0;
         end
      end
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL sim_pending got=%0d exp=0", sb.size()); end
      idle_masters();
      mode = 0;
   endtask

   task automatic test_fairness();
      exp_t        e;
      int          rem0 = 8, rem1 = 8, seq = 0;
      logic [31:0] a0 = 32'h3000, a1 = 32'h4000;
      do_reset();
      mode = 0;
      for (int k = 0; k < 16; k++)
         sb.push_back('{k % 2, model_rd(((k % 2) != 0 ? 32'h4000 : 32'h3000) + 32'(4 * (k / 2))), 1'b1});
      @(posedge clk); #1;
      m0_valid = 1'b1; m0_addr = a0; m1_valid = 1'b1; m1_addr = a1;
      for (int c = 0; c < 120 && (rem0 > 0 || rem1 > 0); c++) begin
         @(negedge clk);
         if (m0_ready === 1'b1 || m1_ready === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin errors++; $display("FAIL fair_extra got=%b%b exp=none", m1_ready, m0_ready); end
            else begin
               e = sb.pop_front();
               if (m0_ready === m1_ready || (e.m == 0 ? (m0_ready !== 1'b1 || m0_rdata !== e.d) : (m1_ready !== 1'b1 || m1_rdata !== e.d)))
                  begin errors++; $display("FAIL fair_seq n=%0d got=%b%b/%h/%h exp=m%0d/%h", seq, m1_ready, m0_ready, m0_rdata, m1_rdata, e.m, e.d); end
            end
            seq++;
            if (m0_ready === 1'b1) begin rem0--; a0 = a0 + 4; end
            if (m1_ready === 1'b1) begin rem1--; a1 = a1 + 4; end
         end
         @(posedge clk); #1;
         m0_valid = (rem0 > 0); m0_addr = a0;
         m1_valid = (rem1 > 0); m1_addr = a1;
      end
      checks++; if (rem0 != 0 || rem1 != 0) begin errors++; $display("FAIL fair_budget left=%0d/%0d exp=0/0", rem0, rem1); end
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL fair_pending got=%0d exp=0", sb.size()); end
      idle_masters();
   endtask

   task automatic test_timeout();
      exp_t e;
      int   first = -1, rdy_cyc = -1, pulses = 0;
      mode = 2;
      sb.push_back('{1, 32'hFFFF_FFFF, 1'b1});
      @(posedge clk); #1;
      m1_valid = 1'b1; m1_addr = 32'hDEAD_0000; m1_wstrb = 4'h0;
      for (int c = 0; c < 40 && rdy_cyc < 0; c++) begin
         @(negedge clk);
         if (s_valid === 1'b1 && first < 0) first = c;
         if (timeout === 1'b1) pulses++;
         if (m1_ready === 1'b1) begin
            rdy_cyc = c;
            e = sb.pop_front();
            checks++; if (e.m != 1 || m1_rdata !== e.d) begin errors++; $display("FAIL to_rdata got=%h exp=%h", m1_rdata, e.d); end
            checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_pulse got=%b exp=1", timeout); end
            checks++; if (s_valid !== 1'b0 || s_wstrb !== 4'h0) begin errors++; $display("FAIL to_svalid got=%b/%h exp=0/0", s_valid, s_wstrb); end
         end else begin
            @(posedge clk); #1;
         end
      end
      checks++; if (rdy_cyc < 0 || first < 0 || rdy_cyc - first != TO - 1) begin errors++; $display("FAIL to_latency got=%0d exp=%0d", rdy_cyc - first, TO - 1); end
      @(posedge clk); #1;
      m1_valid = 1'b0;
      @(negedge clk);
      if (timeout === 1'b1) pulses++;
      checks++; if (pulses != 1) begin errors++; $display("FAIL to_pulse_count got=%0d exp=1", pulses); end
      checks++; if (s_valid !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL to_after got=%b/%b exp=0/00", s_valid, grant); end
      mode = 0;
   endtask

   task automatic test_coincide();
      int pulses = 0;
      mode = 3; force_ready = 1'b0;
      @(posedge clk); #1;
      m0_valid = 1'b1; m0_addr = 32'h5000;
      for (int i = 1; i <= TO; i++) begin
         @(posedge clk); #1;
         if (i == TO) begin force_ready = 1'b1; rd_ovr_en = 1'b1; rd_ovr = 32'hA5A5_A5A5; end
         @(negedge clk);
         if (timeout === 1'b1) pulses++;
         if (i == TO) begin
            checks++; if (m0_ready !== 1'b1 || m0_rdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL co_rdata got=%b/%h exp=1/a5a5a5a5", m0_ready, m0_rdata); end
            checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL co_timeout got=%b exp=0", timeout); end
         end else if (m0_ready !== 1'b0) begin
            checks++; errors++; $display("FAIL co_early_ready cycle=%0d got=1 exp=0", i);
         end
      end
      @(posedge clk); #1;
      m0_valid = 1'b0; force_ready = 1'b0; rd_ovr_en = 1'b0;
      @(negedge clk);
      checks++; if (pulses != 0 || grant !== 2'b00) begin errors++; $display("FAIL co_after got=%0d/%b exp=0/00", pulses, grant); end
      mode = 0;
   endtask

   task automatic test_reset_busy();
      exp_t e;
      int   got = 0;
      mode = 0;
      @(posedge clk); #1;
      m0_valid = 1'b1; m0_addr = 32'h6000;
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (m0_ready !== 1'b1) begin errors++; $display("FAIL rb_prefill got=%b exp=1", m0_ready); end
      @(posedge clk); #1;
      m0_valid = 1'b0; mode = 2;
      m1_valid = 1'b1; m1_addr = 32'h7000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (grant !== 2'b10) begin errors++; $display("FAIL rb_stalled_grant got=%b exp=10", grant); end
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      checks++; if (m0_ready !== 1'b0 || m1_ready !== 1'b0) begin errors++; $display("FAIL rb_ready_in_rst got=%b%b exp=00", m1_ready, m0_ready); end
      @(posedge clk); #1;
      rst = 1'b0; mode = 0;
      m0_valid = 1'b1; m0_addr = 32'h8000;
      sb.push_back('{0, model_rd(32'h8000), 1'b1});
      sb.push_back('{1, model_rd(32'h7000), 1'b1});
      @(negedge clk);
      checks++; if (grant !== 2'b00 || s_valid !== 1'b0) begin errors++; $display("FAIL rb_after got=%b/%b exp=00/0", grant, s_valid); end
      checks++; if (m0_ready !== 1'b0 || m1_ready !== 1'b0) begin errors++; $display("FAIL rb_no_pulse got=%b%b exp=00", m1_ready, m0_ready); end
      for (int c = 0; c < 12 && got < 2; c++) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (m0_ready === 1'b1 || m1_ready === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin errors++; $display("FAIL rb_extra got=%b%b exp=none", m1_ready, m0_ready); end
            else begin
               e = sb.pop_front();
               if (e.m == 0 ? (m0_ready !== 1'b1 || m0_rdata !== e.d) : (m1_ready !== 1'b1 || m1_rdata !== e.d))
                  begin errors++; $display("FAIL rb_tie got=%b%b/%h/%h exp=m%0d/%h", m1_ready, m0_ready, m0_rdata, m1_rdata, e.m, e.d); end
            end
            got++;
            if (m0_ready === 1'b1) m0_valid = 1'b0;
            if (m1_ready === 1'b1) m1_valid = 1'b0;
         end
      end
      checks++; if (got != 2 || sb.size() != 0) begin errors++; $display("FAIL rb_done got=%0d exp=2", got); end
      idle_masters();
   endtask

   initial begin
      idle_masters();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      test_reset();
      test_single();
      test_simultaneous();
      test_fairness();
      test_timeout();
      test_coincide();
      test_reset_busy();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_watchdog got=stuck exp=finished");
      $fatal(1);
   end

endmodule
